// File: rtl/fp_pkg.sv
// Shared constants and types for the FP multiplier datapath: rounding-mode
// encodings, default field widths, bias / product widths and result field offsets.
package fp_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rmode_e;

  localparam int EXP_W_DEF  = 8;
  localparam int MAN_W_DEF  = 23;
  localparam int BIAS_DEF   = (1 << (EXP_W_DEF - 1)) - 1;
  localparam int PROD_W_DEF = 2 * (MAN_W_DEF + 1);

  localparam int MAN_LSB_DEF  = 0;
  localparam int EXP_LSB_DEF  = MAN_W_DEF;
  localparam int SIGN_POS_DEF = EXP_W_DEF + MAN_W_DEF;

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int prod_width(input int man_w);
    return 2 * (man_w + 1);
  endfunction

  // Overflow saturates to infinity only when the mode rounds away from zero for this sign.
  function automatic logic ovf_to_inf(input rmode_e rm, input logic sign);
    logic r;
    case (rm)
      RM_RNE:  r = 1'b1;
      RM_RTZ:  r = 1'b0;
      RM_RUP:  r = ~sign;
      RM_RDN:  r = sign;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fp_round_inc.sv
// Round-increment decision for one significand: (lsb, guard, sticky, sign, mode) -> inc.
module fp_round_inc
  import fp_pkg::*;
(
  input  logic   lsb,
  input  logic   guard,
  input  logic   sticky,
  input  logic   sign,
  input  rmode_e rmode,
  output logic   inc
);

  // Increment selection per rounding mode.
  always_comb begin
    inc = 1'b0;
    case (rmode)
      RM_RNE:  inc = guard & (sticky | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = (guard | sticky) & ~sign;
      RM_RDN:  inc = (guard | sticky) & sign;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_mul_norm_round_pipe.sv
// Two-stage normalise (S1) and round/exception (S2) pipeline of the FP multiplier.
// Optional FPMUL_RMODE_EN adds the in_rmode port; without it rounding is fixed RNE.
module fp_mul_norm_round_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W  = EXP_W_DEF,
  parameter  int MAN_W  = MAN_W_DEF,
  localparam int PROD_W = 2 * (MAN_W + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic                   in_zero,
  input  logic [EXP_W+1:0]       in_exp,
  input  logic [PROD_W-1:0]      in_prod,
`ifdef FPMUL_RMODE_EN
  input  logic [1:0]             in_rmode,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic                   out_ovf,
  output logic                   out_unf,
  output logic                   out_inexact
);

  // One extra exponent bit beyond the input so +1 (normalise) and +1 (rollover) never wrap.
  localparam int EW = EXP_W + 3;
  localparam logic signed [EW-1:0] EXP_OVF  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);
  localparam logic signed [EW-1:0] EXP_INC  = EW'(1);
  localparam logic [EXP_W-1:0] EXP_ALL1 = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0] EXP_NULL = {EXP_W{1'b0}};
  localparam logic [MAN_W-1:0] MAN_ALL1 = {MAN_W{1'b1}};
  localparam logic [MAN_W-1:0] MAN_NULL = {MAN_W{1'b0}};

  logic s1_en_s;
  logic s2_en_s;

  logic                 s1_valid_r;
  logic                 s1_sign_r;
  logic                 s1_zero_r;
  logic signed [EW-1:0] s1_exp_r;
  logic [MAN_W-1:0]     s1_man_r;
  logic                 s1_guard_r;
  logic                 s1_sticky_r;
  rmode_e               s1_rmode_r;

  logic                 out_valid_r;
  logic [EXP_W+MAN_W:0] out_result_r;
  logic                 out_ovf_r;
  logic                 out_unf_r;
  logic                 out_inexact_r;

  logic signed [EW-1:0] n1_exp_s;
  logic [MAN_W-1:0]     n1_man_s;
  logic                 n1_guard_s;
  logic                 n1_sticky_s;
  rmode_e               n1_rmode_s;

  logic                 inc_s;
  logic                 carry_s;
  logic [MAN_W-1:0]     man_rnd_s;
  logic signed [EW-1:0] exp_rnd_s;
  logic                 ovf_s;
  logic                 unf_s;
  logic                 to_inf_s;
  logic [EXP_W-1:0]     res_exp_s;
  logic [MAN_W-1:0]     res_man_s;
  logic                 res_ovf_s;
  logic                 res_unf_s;
  logic                 res_inexact_s;

  assign s2_en_s  = ~out_valid_r | out_ready;
  assign s1_en_s  = ~s1_valid_r | s2_en_s;
  assign in_ready = s1_en_s;

  assign out_valid   = out_valid_r;
  assign out_result  = out_result_r;
  assign out_ovf     = out_ovf_r;
  assign out_unf     = out_unf_r;
  assign out_inexact = out_inexact_r;

`ifdef FPMUL_RMODE_EN
  assign n1_rmode_s = rmode_e'(in_rmode);
`else
  assign n1_rmode_s = RM_RNE;
`endif

  // S1 normalise: pick the significand window by the product MSB; the hidden bit is not kept.
  always_comb begin
    n1_exp_s    = $signed({in_exp[EXP_W+1], in_exp});
    n1_man_s    = in_prod[PROD_W-3 -: MAN_W];
    n1_guard_s  = in_prod[MAN_W-1];
    n1_sticky_s = |in_prod[MAN_W-2:0];
    if (in_prod[PROD_W-1]) begin
      n1_exp_s    = $signed({in_exp[EXP_W+1], in_exp}) + EXP_INC;
      n1_man_s    = in_prod[PROD_W-2 -: MAN_W];
      n1_guard_s  = in_prod[MAN_W];
      n1_sticky_s = |in_prod[MAN_W-1:0];
    end else begin
      n1_exp_s    = $signed({in_exp[EXP_W+1], in_exp});
      n1_man_s    = in_prod[PROD_W-3 -: MAN_W];
      n1_guard_s  = in_prod[MAN_W-1];
      n1_sticky_s = |in_prod[MAN_W-2:0];
    end
  end

  // S1 pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_sign_r   <= 1'b0;
      s1_zero_r   <= 1'b0;
      s1_exp_r    <= EXP_ZERO;
      s1_man_r    <= MAN_NULL;
      s1_guard_r  <= 1'b0;
      s1_sticky_r <= 1'b0;
      s1_rmode_r  <= RM_RNE;
    end else if (s1_en_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sign_r   <= in_sign;
        s1_zero_r   <= in_zero;
        s1_exp_r    <= n1_exp_s;
        s1_man_r    <= n1_man_s;
        s1_guard_r  <= n1_guard_s;
        s1_sticky_r <= n1_sticky_s;
        s1_rmode_r  <= n1_rmode_s;
      end
    end
  end

  fp_round_inc u_round_inc (
    .lsb    (s1_man_r[0]),
    .guard  (s1_guard_r),
    .sticky (s1_sticky_r),
    .sign   (s1_sign_r),
    .rmode  (s1_rmode_r),
    .inc    (inc_s)
  );

  // Rollover happens only when the stored mantissa is all ones; it then wraps to zero.
  assign carry_s   = (&s1_man_r) & inc_s;
  assign man_rnd_s = s1_man_r + {{(MAN_W-1){1'b0}}, inc_s};
  assign exp_rnd_s = s1_exp_r + (carry_s ? EXP_INC : EXP_ZERO);
  assign ovf_s     = (exp_rnd_s >= EXP_OVF);
  assign unf_s     = (exp_rnd_s <= EXP_ZERO);
  assign to_inf_s  = ovf_to_inf(s1_rmode_r, s1_sign_r);

  // S2 exception mux; an exact zero operand overrides overflow and underflow.
  always_comb begin
    res_exp_s     = exp_rnd_s[EXP_W-1:0];
    res_man_s     = man_rnd_s;
    res_ovf_s     = 1'b0;
    res_unf_s     = 1'b0;
    res_inexact_s = s1_guard_r | s1_sticky_r;
    if (s1_zero_r) begin
      res_exp_s     = EXP_NULL;
      res_man_s     = MAN_NULL;
      res_inexact_s = 1'b0;
    end else if (ovf_s) begin
      res_ovf_s     = 1'b1;
      res_inexact_s = 1'b1;
      if (to_inf_s) begin
        res_exp_s = EXP_ALL1;
        res_man_s = MAN_NULL;
      end else begin
        res_exp_s = EXP_MAXF;
        res_man_s = MAN_ALL1;
      end
    end else if (unf_s) begin
      res_unf_s     = 1'b1;
      res_inexact_s = 1'b1;
      res_exp_s     = EXP_NULL;
      res_man_s     = MAN_NULL;
    end else begin
      res_exp_s     = exp_rnd_s[EXP_W-1:0];
      res_man_s     = man_rnd_s;
      res_inexact_s = s1_guard_r | s1_sticky_r;
    end
  end

  // S2 output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      out_result_r  <= {(EXP_W+MAN_W+1){1'b0}};
      out_ovf_r     <= 1'b0;
      out_unf_r     <= 1'b0;
      out_inexact_r <= 1'b0;
    end else if (s2_en_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_result_r  <= {s1_sign_r, res_exp_s, res_man_s};
        out_ovf_r     <= res_ovf_s;
        out_unf_r     <= res_unf_s;
        out_inexact_r <= res_inexact_s;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_norm_round_pipe.sv
// Self-checking bench for fp_mul_norm_round_pipe (EXP_W=8, MAN_W=23): directed vectors,
// backpressure, mid-stream reset and randomized traffic against an integer reference model.
module tb_fp_mul_norm_round_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic        in_zero;
  logic [9:0]  in_exp;
  logic [47:0] in_prod;
  logic [1:0]  rm_cur;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_unf;
  logic        out_inexact;

  int          cur_e;
  int          checks = 0;
  int          failures = 0;
  int          emitted = 0;
  logic [34:0] q[$];
  logic [34:0] obs;

  assign obs = {out_ovf, out_unf, out_inexact, out_result};

  always #5 clk = ~clk;

  fp_mul_norm_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_zero     (in_zero),
    .in_exp      (in_exp),
    .in_prod     (in_prod),
`ifdef FPMUL_RMODE_EN
    .in_rmode    (rm_cur),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_ovf     (out_ovf),
    .out_unf     (out_unf),
    .out_inexact (out_inexact)
  );

  // Reference: exact integer quotient/remainder of the product, rounded by comparing to half.
  function automatic logic [34:0] model(input bit s, input bit z, input int e_in,
                                        input logic [47:0] p, input logic [1:0] rm);
    longint unsigned pl, qv, rem, half;
    int              sh, e;
    bit              inc, inexact, to_inf;
    logic [34:0]     r;
    pl = 64'(p);
    if (p[47]) begin sh = 24; e = e_in + 1; end
    else       begin sh = 23; e = e_in;     end
    qv      = pl >> sh;
    rem     = pl & ((64'd1 << sh) - 64'd1);
    half    = 64'd1 << (sh - 1);
    inexact = (rem != 64'd0);
    case (rm)
      2'd0:    inc = (rem > half) || ((rem == half) && qv[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = inexact && !s;
      default: inc = inexact && s;
    endcase
    qv = qv + (inc ? 64'd1 : 64'd0);
    if (qv == (64'd1 << 24)) begin qv = 64'd1 << 23; e = e + 1; end
    to_inf = (rm == 2'd0) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
    if (z)             r = {3'b000, s, 31'd0};
    else if (e >= 255) r = to_inf ? {3'b101, s, 8'hFF, 23'd0} : {3'b101, s, 8'hFE, 23'h7FFFFF};
    else if (e <= 0)   r = {3'b011, s, 31'd0};
    else               r = {2'b00, inexact, s, e[7:0], qv[22:0]};
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] x);
    checks++;
    assert (o === x) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  task automatic set_in(input bit v, input bit s, input bit z, input int e,
                        input logic [47:0] p, input logic [1:0] rm);
    in_valid = v; in_sign = s; in_zero = z; in_exp = e[9:0];
    in_prod = p; rm_cur = rm; cur_e = e;
  endtask

  // One clock: scoreboard outputs, record accepted inputs, advance to the next falling edge.
  task automatic cycle();
    #1;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) check("spurious_out", 64'(out_valid), 64'd0);
      else if (out_ready) begin check("result", 64'(obs), 64'(q.pop_front())); emitted++; end
      else check("hold_stable", 64'(obs), 64'(q[0]));
    end
    if (in_valid && in_ready === 1'b1) q.push_back(model(in_sign, in_zero, cur_e, in_prod, rm_cur));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input bit s, input bit z, input int e,
                          input logic [47:0] p, input logic [1:0] rm, input logic [34:0] want);
    out_ready = 1'b1;
    set_in(1'b1, s, z, e, p, rm);
    cycle();
    set_in(1'b0, s, z, e, p, rm);
    #1;
    check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    cycle();
    #1;
    check(tag, 64'({out_valid, obs}), 64'({1'b1, want}));
    cycle();
  endtask

  logic [47:0] bp_p[4];
  int          bp_e[4];

  initial begin
    logic [63:0] r64;
    bit          pending, acc;
    int          sent, emitted0;
    rst_n = 1'b0; out_ready = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 0, 48'd0, 2'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_data", 64'(obs), 64'd0);

    directed("mul_1p5",   1'b0, 1'b0, 127, 48'h9000_0000_0000, 2'd0, {3'b000, 32'h4010_0000});
    directed("tie_even",  1'b0, 1'b0, 127, 48'h4000_0040_0000, 2'd0, {3'b001, 32'h3F80_0000});
    directed("tie_odd",   1'b0, 1'b0, 127, 48'h4000_00C0_0000, 2'd0, {3'b001, 32'h3F80_0002});
    directed("rollover",  1'b0, 1'b0, 127, 48'h7FFF_FFFF_FFFF, 2'd0, {3'b001, 32'h4000_0000});
    directed("overflow",  1'b0, 1'b0, 254, 48'h8000_0000_0000, 2'd0, {3'b101, 32'h7F80_0000});
    directed("roll_ovf",  1'b1, 1'b0, 254, 48'h7FFF_FFFF_FFFF, 2'd0, {3'b101, 32'hFF80_0000});
    directed("max_norm",  1'b0, 1'b0, 253, 48'h8000_0000_0000, 2'd0, {3'b000, 32'h7F00_0000});
    directed("min_norm",  1'b0, 1'b0, 1,   48'h4000_0000_0000, 2'd0, {3'b000, 32'h0080_0000});
    directed("underflow", 1'b0, 1'b0, -5,  48'h4000_0000_0000, 2'd0, {3'b011, 32'h0000_0000});
    directed("unf_edge",  1'b1, 1'b0, -1,  48'h8000_0000_0000, 2'd0, {3'b011, 32'h8000_0000});
    directed("zero_neg",  1'b1, 1'b1, 127, 48'h0000_0000_0000, 2'd0, {3'b000, 32'h8000_0000});
    directed("zero_ovr",  1'b0, 1'b1, 300, 48'hFFFF_FFFF_FFFF, 2'd0, {3'b000, 32'h0000_0000});
`ifdef FPMUL_RMODE_EN
    directed("ovf_rtz",   1'b0, 1'b0, 254, 48'h8000_0000_0000, 2'd1, {3'b101, 32'h7F7F_FFFF});
    directed("ovf_rdn",   1'b1, 1'b0, 254, 48'h8000_0000_0000, 2'd3, {3'b101, 32'hFF80_0000});
    directed("rup_pos",   1'b0, 1'b0, 127, 48'h4000_0000_0001, 2'd2, {3'b001, 32'h3F80_0001});
`endif

    // Backpressure: four beats, downstream stalled for the first cycles.
    for (int i = 0; i < 4; i++) begin
      r64 = {$urandom(), $urandom()};
      bp_p[i] = r64[47:0] | 48'h4000_0000_0000;
      bp_e[i] = 100 + i;
    end
    sent = 0; emitted0 = emitted;
    for (int c = 0; c < 40 && (sent < 4 || q.size() > 0); c++) begin
      out_ready = (c >= 5);
      if (sent < 4) set_in(1'b1, 1'b0, 1'b0, bp_e[sent], bp_p[sent], 2'd0);
      else          set_in(1'b0, 1'b0, 1'b0, 0, 48'd0, 2'd0);
      #1;
      if (c == 2) check("bp_in_ready_low", 64'(in_ready), 64'd0);
      acc = in_valid && in_ready;
      cycle();
      if (acc) sent++;
    end
    check("bp_emitted", 64'(emitted - emitted0), 64'd4);
    check("bp_drained", 64'(q.size()), 64'd0);

    // Reset with both stages full: nothing may come out afterwards.
    out_ready = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 120, 48'h5555_5555_5555, 2'd0); cycle();
    set_in(1'b1, 1'b1, 1'b0, 130, 48'hAAAA_AAAA_AAAA, 2'd0); cycle();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 0, 48'd0, 2'd0);
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cycle();
    check("rst_no_output", 64'(out_valid), 64'd0);

    // Randomized traffic with random backpressure; a refused beat is held unchanged.
    pending = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!pending) begin
        r64 = {$urandom(), $urandom()};
        if (r64[47:46] == 2'b00) r64[46] = 1'b1;
        if ($urandom_range(0, 7) == 0) begin r64[21:0] = 22'd0; r64[22] = 1'b1; end
        set_in($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
               int'($urandom_range(0, 300)) - 20, r64[47:0],
`ifdef FPMUL_RMODE_EN
               2'($urandom_range(0, 3)));
`else
               2'd0);
`endif
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      cycle();
      pending = in_valid && !acc;
    end
    set_in(1'b0, 1'b0, 1'b0, 0, 48'd0, 2'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() > 0; c++) cycle();
    check("final_drain", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
